int_muldiv_unit: RTL and testbench
==================================

INT_MULDIV_UNIT -- requirements
Module: int_muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32; operand and result width. All widths and values below are for WIDTH=32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe from the EX stage; sampled on rising clk.
REQ-005 SHALL have port op  input  4  integer opcode: 4'b0011 mul, 4'b0100 div, 4'b0101 mod.
REQ-006 SHALL have port A  input  WIDTH  first operand (multiplicand / dividend).
REQ-007 SHALL have port B  input  WIDTH  second operand (multiplier / divisor).
REQ-008 SHALL have port busy  output  1  high while a request is in progress; the EX stage stalls on it.
REQ-009 SHALL have port done  output  1  one-cycle pulse; Z holds the new result in that cycle.
REQ-010 SHALL have port Z  output  WIDTH  registered result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-012 SHALL accept a request only in IDLE with start=1, latching A, B and op at that edge.
REQ-013 SHALL ignore start while busy=1; latched operands SHALL NOT change while busy.
REQ-014 SHALL treat all operands as unsigned.
REQ-015 SHALL perform mul as shift-add, one multiplier bit per cycle, over exactly 32 RUN cycles.
REQ-016 SHALL set Z for mul to the low 32 bits of A*B.
REQ-017 SHALL perform div/mod as restoring division, one quotient bit per cycle, over exactly 32 RUN cycles.
REQ-018 SHALL set Z for div to floor(A/B) and Z for mod to A mod B.
REQ-019 SHALL apply this latency when start is sampled in cycle N: RUN in cycles N+1..N+32, DONE (done=1, Z valid) in cycle N+33, IDLE in cycle N+34.
REQ-020 SHALL accept a new start in the IDLE cycle N+34; a start during the DONE cycle SHALL be ignored.
REQ-021 SHALL handle divide-by-zero (B=0, op div/mod) by skipping RUN: DONE in cycle N+1, Z=32'hFFFFFFFF for div, Z=A for mod.
REQ-022 SHALL handle any opcode other than 0011/0100/0101 by skipping RUN: DONE in cycle N+1 with Z=0.
REQ-023 SHALL use a 5-bit iteration counter: cleared on accept, incremented each RUN cycle, RUN->DONE on the edge where the count reaches 31.
REQ-024 SHALL hold Z between done pulses; Z SHALL be updated only on entry to DONE.
REQ-025 SHALL NOT let intermediate partial products or remainders appear on Z.

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, busy=0, done=0, Z=0, counter=0, with no dependence on clk.
REQ-027 SHALL, on rst asserted mid-RUN, abandon the operation: no done pulse and Z=0.
REQ-028 SHALL, after rst deasserts, accept start on the first rising clk edge.

Verification
REQ-029 SHALL verify mul: A=7, B=6, op=0011, start in cycle 0 -> busy=1 in cycles 1-33, done=1 only in cycle 33 with Z=42, busy=0 in cycle 34.
REQ-030 SHALL verify div and mod: A=100, B=7 -> div gives Z=14; mod gives Z=2; done in cycle 33 in both cases.
REQ-031 SHALL verify wrap and unsigned behaviour: mul A=32'hFFFFFFFF, B=2 -> Z=32'hFFFFFFFE; div A=32'h80000000, B=2 -> Z=32'h40000000.
REQ-032 SHALL verify divide-by-zero: div A=5, B=0 -> done in cycle 1 with Z=32'hFFFFFFFF; mod A=5, B=0 -> Z=5.
REQ-033 SHALL verify the handshake: a second start in cycles 5 and 33 with different operands is ignored (Z=42 for the first request); a start in cycle 34 is accepted, giving done in cycle 67.
REQ-034 SHALL verify reset mid-operation: rst pulse in cycle 10 of a mul -> busy=0, done=0, Z=0 immediately; no done is seen afterward; a fresh request completes normally.

Source files
------------

// File: rtl/int_muldiv_unit_if.sv
// rtl/int_muldiv_unit_if.sv - request/result bundle between the EX stage and the mul/div unit
//
// Signals:
//   start  EX -> unit   request strobe, sampled on rising clk
//   op     EX -> unit   4-bit opcode (0011 mul, 0100 div, 0101 mod)
//   A, B   EX -> unit   operands (multiplicand/dividend, multiplier/divisor)
//   busy   unit -> EX   request in progress, EX stalls on it
//   done   unit -> EX   one-cycle pulse, Z carries the new result
//   Z      unit -> EX   registered result
interface int_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Z;

    modport master (
        output start, op, A, B,
        input  busy, done, Z
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, Z
    );
endinterface

// File: rtl/int_muldiv_unit.sv
// rtl/int_muldiv_unit.sv - iterative unsigned multiply / divide / modulo unit
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   int_muldiv_unit_if.slave (start/op/A/B in, busy/done/Z out)
//
// mul is shift-add and div/mod is restoring division, one bit per RUN cycle,
// WIDTH RUN cycles per request. Divide-by-zero and unknown opcodes go
// straight from IDLE to DONE.
module int_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    int_muldiv_unit_if.slave  bus
);
    localparam int               CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST   = CW'(WIDTH - 1);
    localparam logic [3:0]       OP_MUL = 4'b0011;
    localparam logic [3:0]       OP_DIV = 4'b0100;
    localparam logic [3:0]       OP_MOD = 4'b0101;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       op_q;
    // Shared datapath registers:
    //   mul: x = accumulator, y = shifted multiplicand, w = shifted multiplier
    //   div: x = partial remainder, y = divisor, w = dividend shifting into quotient
    logic [WIDTH-1:0] x_q, y_q, w_q;
    logic [WIDTH-1:0] z_q;

    logic             accept;
    logic             is_divmod;
    logic             fast;
    logic [WIDTH-1:0] fast_z;

    logic [WIDTH:0]   sh;
    logic             ge;
    logic [WIDTH-1:0] x_n, y_n, w_n;

    assign accept    = (state_q == IDLE) && bus.start;
    assign is_divmod = (bus.op == OP_DIV) || (bus.op == OP_MOD);
    assign fast      = !((bus.op == OP_MUL) || is_divmod) || (is_divmod && (bus.B == '0));

    always_comb begin
        fast_z = '0;
        if (bus.op == OP_DIV)
            fast_z = '1;
        else if (bus.op == OP_MOD)
            fast_z = bus.A;
    end

    // One iteration step of whichever operation is latched.
    always_comb begin
        sh = {x_q, w_q[WIDTH-1]};
        ge = (sh >= {1'b0, y_q});
        if (op_q == OP_MUL) begin
            x_n = w_q[0] ? (x_q + y_q) : x_q;
            y_n = y_q << 1;
            w_n = w_q >> 1;
        end else begin
            // The difference is below the divisor, so it fits in WIDTH bits.
            x_n = ge ? (sh[WIDTH-1:0] - y_q) : sh[WIDTH-1:0];
            y_n = y_q;
            w_n = {w_q[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_n = fast ? DONE : RUN;
            RUN:     if (cnt_q == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            w_q   <= '0;
            z_q   <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            op_q  <= bus.op;
            x_q   <= '0;
            y_q   <= (bus.op == OP_MUL) ? bus.A : bus.B;
            w_q   <= (bus.op == OP_MUL) ? bus.B : bus.A;
            if (fast)
                z_q <= fast_z;
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            x_q   <= x_n;
            y_q   <= y_n;
            w_q   <= w_n;
            // Z only moves on the final step, so partial results never show.
            if (cnt_q == LAST)
                z_q <= (op_q == OP_DIV) ? w_n : x_n;
        end
    end

    assign bus.Z = z_q;
endmodule

// File: tb/tb_int_muldiv_unit.sv
// tb/tb_int_muldiv_unit.sv - directed self-checking bench for int_muldiv_unit
module tb_int_muldiv_unit;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    int_muldiv_unit_if #(.WIDTH(32)) bus ();

    int_muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge, which is cycle 0; start is sampled at the next posedge.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_z, input int exp_cyc);
        int          done_cyc = -1;
        int          done_cnt = 0;
        bit          busy_ok  = 1'b1;
        logic [31:0] zval     = 'x;
        logic        busy_after = 1'bx;
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        for (int c = 1; c <= exp_cyc + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0; bus.op = 4'hF;
                bus.A = $urandom; bus.B = $urandom;
            end
            if (c <= exp_cyc && !bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    zval     = bus.Z;
                end
            end
            if (c == exp_cyc + 1) busy_after = bus.busy;
        end
        check({tag, " done_cycle"}, done_cyc, exp_cyc);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_held"}, {31'd0, busy_ok}, 1);
        check({tag, " busy_after"}, {31'd0, busy_after}, 0);
        check({tag, " Z"}, zval, exp_z);
    endtask

    initial begin
        #50_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dcount, d1, d2;
        logic [31:0] z1, z2;

        bus.start = 1'b0; bus.op = OP_MUL; bus.A = '0; bus.B = '0;
        #2;
        check("reset busy", {31'd0, bus.busy}, 0);
        check("reset done", {31'd0, bus.done}, 0);
        check("reset Z", bus.Z, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul 7*6", OP_MUL, 32'd7, 32'd6, 32'd42, 33);
        run_op("div 100/7", OP_DIV, 32'd100, 32'd7, 32'd14, 33);
        run_op("mod 100%7", OP_MOD, 32'd100, 32'd7, 32'd2, 33);
        run_op("mul wrap", OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        run_op("div unsigned", OP_DIV, 32'h80000000, 32'd2, 32'h40000000, 33);
        run_op("mul shift", OP_MUL, 32'h12345678, 32'h10, 32'h23456780, 33);
        run_op("div big", OP_DIV, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33);
        run_op("mod big", OP_MOD, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 33);
        run_op("div by 0", OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        run_op("mod by 0", OP_MOD, 32'd5, 32'd0, 32'd5, 1);
        run_op("bad op", 4'b0000, 32'd3, 32'd4, 32'd0, 1);

        // Handshake: starts in cycles 5 and 33 ignored, start in 34 accepted.
        dcount = 0; d1 = -1; d2 = -1; z1 = 'x; z2 = 'x;
        bus.start = 1'b1; bus.op = OP_MUL; bus.A = 32'd7; bus.B = 32'd6;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dcount++;
                if (dcount == 1) begin d1 = c; z1 = bus.Z; end
                else if (dcount == 2) begin d2 = c; z2 = bus.Z; end
            end
            bus.start = (c == 5) || (c == 33) || (c == 34);
            bus.op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
        end
        bus.start = 1'b0;
        check("hs first done_cycle", d1, 33);
        check("hs first Z", z1, 32'd42);
        check("hs second done_cycle", d2, 67);
        check("hs second Z", z2, 32'd14);
        check("hs done_pulses", dcount, 2);

        // Reset in cycle 10 of a multiply.
        bus.start = 1'b1; bus.op = OP_MUL; bus.A = 32'd7; bus.B = 32'd6;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("rst pre busy", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        #1;
        check("rst mid busy", {31'd0, bus.busy}, 0);
        check("rst mid done", {31'd0, bus.done}, 0);
        check("rst mid Z", bus.Z, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        check("rst no activity", dcount, 0);
        check("rst Z held", bus.Z, 0);
        run_op("mul after rst", OP_MUL, 32'd7, 32'd6, 32'd42, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
